// File: rtl/para_reply_framer_if.sv
// Signal bundle between the parameter-reply framer, its request source and the
// UART it feeds. The framer side uses the master modport.
interface para_reply_framer_if #(
    parameter int NUM_FIELDS = 6
);
    logic                     enquire_flag;
    logic [7:0]               ctrl_code;
    logic [32*NUM_FIELDS-1:0] field_data;
    logic                     tx_idle;
    logic [7:0]               tx_data;
    logic                     start_tx;
    logic                     busy;
    logic                     done;
    logic                     err;
    logic [2:0]               fsm_state;

    // Handshake: start_tx is a one-cycle strobe qualifying tx_data, and tx_data
    // is held until the UART reports the byte done with a falling tx_idle.
    // enquire_flag is a level sampled only while idle; there is no ready path
    // back to the requester, so a request raised while busy is simply dropped.
    modport master (
        input  enquire_flag,
        input  ctrl_code,
        input  field_data,
        input  tx_idle,
        output tx_data,
        output start_tx,
        output busy,
        output done,
        output err,
        output fsm_state
    );

    modport slave (
        output enquire_flag,
        output ctrl_code,
        output field_data,
        output tx_idle,
        input  tx_data,
        input  start_tx,
        input  busy,
        input  done,
        input  err,
        input  fsm_state
    );
endinterface

// File: rtl/para_reply_framer.sv
// Serialises a snapshot of NUM_FIELDS 32-bit parameters into a byte frame
// (start, ctrl, length, payload, checksum, end) one UART byte at a time.
module para_reply_framer #(
    parameter int         NUM_FIELDS = 6,
    parameter logic [7:0] START_CODE = 8'hAA,
    parameter logic [7:0] END_CODE   = 8'h55,
    parameter int         TX_TIMEOUT = 100000
) (
    input  logic                clk,
    input  logic                rst_n,
    para_reply_framer_if.master bus
);
    localparam int          LEN      = 4 * NUM_FIELDS;
    localparam logic [15:0] LEN16    = 16'(LEN);
    localparam logic [6:0]  CHK_IDX  = 7'(LEN + 4);
    localparam logic [6:0]  LAST_IDX = 7'(LEN + 5);
    localparam logic [23:0] TO_LAST  = 24'(TX_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SEND = 3'd2,
        WAIT = 3'd3,
        FIN  = 3'd4
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [6:0]               idx;
    logic [7:0]               chk_sum;
    logic [23:0]              to_cnt;
    logic [7:0]               ctrl_snap;
    logic [32*NUM_FIELDS-1:0] field_snap;
    logic [7:0]               tx_data_q;
    logic                     start_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     err_q;
    logic                     sync_q1;
    logic                     sync_q2;
    logic                     tx_done;
    logic [6:0]               pay_idx;
    logic [7:0]               pay_byte;
    logic [7:0]               sel_byte;
    logic                     in_sum;
    logic                     timeout_hit;

    // tx_idle comes from another clock domain; its falling edge marks byte done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= bus.tx_idle;
            sync_q2 <= sync_q1;
        end
    end

    assign tx_done = sync_q2 & ~sync_q1;

    always_comb begin
        pay_idx  = idx - 7'd4;
        pay_byte = 8'h00;
        for (int j = 0; j < LEN; j++) begin
            if (pay_idx == 7'(j)) pay_byte = field_snap[8*j +: 8];
        end
        sel_byte = pay_byte;
        if (idx == 7'd0)           sel_byte = START_CODE;
        else if (idx == 7'd1)      sel_byte = ctrl_snap;
        else if (idx == 7'd2)      sel_byte = LEN16[7:0];
        else if (idx == 7'd3)      sel_byte = LEN16[15:8];
        else if (idx == CHK_IDX)   sel_byte = ~chk_sum;
        else if (idx == LAST_IDX)  sel_byte = END_CODE;
    end

    // Checksum covers ctrl, both length bytes and the payload.
    assign in_sum      = (idx != 7'd0) && (idx < CHK_IDX);
    // A byte-done landing on the terminal count wins over the timeout.
    assign timeout_hit = (state == WAIT) && !tx_done && (to_cnt == TO_LAST);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.enquire_flag) state_next = LOAD;
            LOAD: state_next = SEND;
            SEND: state_next = WAIT;
            WAIT: begin
                if (tx_done)          state_next = (idx < LAST_IDX) ? LOAD : FIN;
                else if (timeout_hit) state_next = IDLE;
            end
            FIN:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            chk_sum    <= '0;
            to_cnt     <= '0;
            ctrl_snap  <= '0;
            field_snap <= '0;
            tx_data_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.enquire_flag) begin
                        ctrl_snap  <= bus.ctrl_code;
                        field_snap <= bus.field_data;
                        idx        <= '0;
                        chk_sum    <= '0;
                    end
                end
                LOAD: begin
                    tx_data_q <= sel_byte;
                    if (in_sum) chk_sum <= chk_sum + sel_byte;
                end
                SEND: to_cnt <= '0;
                WAIT: begin
                    to_cnt <= to_cnt + 24'd1;
                    if (tx_done && (idx < LAST_IDX)) idx <= idx + 7'd1;
                end
                default: ;
            endcase
        end
    end

    // Status outputs are registered decodes of the state just left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            start_q <= (state == SEND);
            busy_q  <= (state != IDLE);
            done_q  <= (state == FIN);
            err_q   <= timeout_hit;
        end
    end

    assign bus.tx_data   = tx_data_q;
    assign bus.start_tx  = start_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.fsm_state = state;

    a_start_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        start_q |=> !start_q);
    a_data_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (state == WAIT) |=> $stable(tx_data_q));
    a_done_err_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(done_q && err_q));
endmodule

// File: tb/tb_para_reply_framer.sv
// Directed bench for para_reply_framer: a 1-field instance for the hand-worked
// frame and a 6-field instance (timeout 64) for the remaining scenarios.
module tb_para_reply_framer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;

    para_reply_framer_if #(.NUM_FIELDS(1)) a_if ();
    para_reply_framer_if #(.NUM_FIELDS(6)) b_if ();

    para_reply_framer #(.NUM_FIELDS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(a_if)
    );
    para_reply_framer #(.NUM_FIELDS(6), .TX_TIMEOUT(64)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(b_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] a_got_q[$];
    logic [7:0] a_exp_q[$];
    logic [7:0] b_got_q[$];
    logic [7:0] exp_q[$];
    int a_start_cnt = 0;
    int a_done_cnt = 0;
    int b_done_cnt = 0;
    int b_err_cnt = 0;
    int b_done_cyc = 0;
    int b_err_cyc = 0;
    int b_busy_at_done = 0;
    int b_start_cyc_q[$];
    int b_busy_rise_q[$];
    logic b_busy_prev = 1'b0;
    int b_model_cnt = 0;
    int b_withhold = 0;

    // ---------------- monitors (sample on the falling edge) ----------------
    always @(negedge clk) begin
        if (a_if.start_tx) begin
            a_got_q.push_back(a_if.tx_data);
            a_start_cnt++;
        end
        if (a_if.done) a_done_cnt++;
        if (b_if.start_tx) begin
            b_got_q.push_back(b_if.tx_data);
            b_start_cyc_q.push_back(cyc);
        end
        if (b_if.done) begin
            b_done_cnt++;
            b_done_cyc = cyc;
            b_busy_at_done = int'(b_if.busy);
        end
        if (b_if.err) begin
            b_err_cnt++;
            b_err_cyc = cyc;
        end
        if (b_if.busy && !b_busy_prev) b_busy_rise_q.push_back(cyc);
        b_busy_prev = b_if.busy;
    end

    // ---------------- UART models ----------------
    initial begin
        a_if.tx_idle = 1'b1;
        forever begin
            @(negedge clk);
            if (a_if.start_tx) begin
                repeat (19) @(negedge clk);
                a_if.tx_idle = 1'b0;
                repeat (2) @(negedge clk);
                a_if.tx_idle = 1'b1;
            end
        end
    end

    initial begin
        b_if.tx_idle = 1'b1;
        forever begin
            @(negedge clk);
            if (b_if.start_tx) begin
                b_model_cnt++;
                if (b_model_cnt != b_withhold) begin
                    repeat (19) @(negedge clk);
                    b_if.tx_idle = 1'b0;
                    repeat (2) @(negedge clk);
                    b_if.tx_idle = 1'b1;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic compare_q(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
        check({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp[i]));
    endtask

    function automatic void build_frame(input logic [7:0] c, input logic [191:0] f);
        logic [7:0] s;
        logic [7:0] b;
        s = c + 8'd24;
        exp_q.push_back(8'hAA);
        exp_q.push_back(c);
        exp_q.push_back(8'd24);
        exp_q.push_back(8'd0);
        for (int i = 0; i < 24; i++) begin
            b = f[8*i +: 8];
            s = s + b;
            exp_q.push_back(b);
        end
        exp_q.push_back(~s);
        exp_q.push_back(8'h55);
    endfunction

    function automatic logic [191:0] rand_fields();
        logic [191:0] f;
        for (int i = 0; i < 6; i++) f[32*i +: 32] = $urandom;
        return f;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clear_b();
        b_got_q.delete();
        exp_q.delete();
        b_start_cyc_q.delete();
        b_busy_rise_q.delete();
        b_model_cnt = 0;
    endtask

    task automatic request_b(input logic [7:0] c, input logic [191:0] f, output int rc);
        @(negedge clk);
        b_if.ctrl_code    = c;
        b_if.field_data   = f;
        b_if.enquire_flag = 1'b1;
        rc = cyc;
        @(negedge clk);
        b_if.enquire_flag = 1'b0;
    endtask

    task automatic wait_b_end(input string tag, input int budget);
        int d0;
        int e0;
        int n;
        d0 = b_done_cnt;
        e0 = b_err_cnt;
        n = 0;
        while (b_done_cnt == d0 && b_err_cnt == e0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check({tag, "_end_seen"}, 32'(n < budget), 32'd1);
    endtask

    task automatic wait_b_bytes(input string tag, input int cnt, input int budget);
        int n;
        n = 0;
        while (b_got_q.size() < cnt && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check({tag, "_bytes_seen"}, 32'(n < budget), 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_tx_data"}, 32'(b_if.tx_data), 32'h0);
        check({tag, "_start_tx"}, 32'(b_if.start_tx), 32'h0);
        check({tag, "_busy"}, 32'(b_if.busy), 32'h0);
        check({tag, "_done"}, 32'(b_if.done), 32'h0);
        check({tag, "_err"}, 32'(b_if.err), 32'h0);
        check({tag, "_state"}, 32'(b_if.fsm_state), 32'h0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int rc;
        int d0;
        int e0;
        int d1;
        logic [191:0] f;

        a_if.enquire_flag = 1'b0;
        a_if.ctrl_code    = 8'h00;
        a_if.field_data   = '0;
        b_if.enquire_flag = 1'b0;
        b_if.ctrl_code    = 8'h00;
        b_if.field_data   = '0;

        repeat (3) @(negedge clk);
        check("rst_a_tx_data", 32'(a_if.tx_data), 32'h0);
        check("rst_a_busy", 32'(a_if.busy), 32'h0);
        check("rst_a_state", 32'(a_if.fsm_state), 32'h0);
        check_idle_outputs("rst_b");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_idle", 32'(b_if.busy), 32'h0);

        // Hand-worked one-field frame: sum 10+04+00+01+02+03+04 = 1E, CHK = E1.
        @(negedge clk);
        a_if.ctrl_code    = 8'h10;
        a_if.field_data   = 32'h04030201;
        a_if.enquire_flag = 1'b1;
        @(negedge clk);
        a_if.enquire_flag = 1'b0;
        n = 0;
        while (a_done_cnt == 0 && n < 1000) begin
            @(negedge clk); #1;
            n++;
        end
        check("a_end_seen", 32'(n < 1000), 32'd1);
        repeat (5) @(negedge clk);
        a_exp_q = '{8'hAA, 8'h10, 8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hE1, 8'h55};
        compare_q("a_frame", a_got_q, a_exp_q);
        check("a_starts", 32'(a_start_cnt), 32'd10);
        check("a_dones", 32'(a_done_cnt), 32'd1);

        // Default frame; inputs change right after the request is sampled.
        clear_b();
        f = rand_fields();
        build_frame(8'h3C, f);
        request_b(8'h3C, f, rc);
        b_if.ctrl_code  = 8'hC3;
        b_if.field_data = ~f;
        wait_b_end("b1", 2000);
        repeat (3) @(negedge clk);
        compare_q("b1_frame", b_got_q, exp_q);
        check("b1_done", 32'(b_done_cnt), 32'd1);
        check("b1_err", 32'(b_err_cnt), 32'd0);
        check("b1_lat_start", 32'((b_start_cyc_q.size() > 0) ? b_start_cyc_q[0] - rc : -1), 32'd3);
        check("b1_lat_busy", 32'((b_busy_rise_q.size() > 0) ? b_busy_rise_q[0] - rc : -1), 32'd2);
        check("b1_busy_rises", 32'(b_busy_rise_q.size()), 32'd1);
        check("b1_busy_at_done", 32'(b_busy_at_done), 32'd1);
        check("b1_busy_after", 32'(b_if.busy), 32'd0);

        // UART never finishes byte 5: err exactly 64 cycles after its start_tx.
        clear_b();
        b_withhold = 6;
        f = rand_fields();
        build_frame(8'h5A, f);
        d0 = b_done_cnt;
        e0 = b_err_cnt;
        request_b(8'h5A, f, rc);
        wait_b_end("to", 2000);
        check("to_err", 32'(b_err_cnt - e0), 32'd1);
        check("to_done", 32'(b_done_cnt - d0), 32'd0);
        check("to_delay", 32'((b_start_cyc_q.size() > 5) ? b_err_cyc - b_start_cyc_q[5] : -1), 32'd64);
        check("to_state", 32'(b_if.fsm_state), 32'd0);
        repeat (100) @(negedge clk);
        check("to_starts", 32'(b_got_q.size()), 32'd6);
        check("to_busy", 32'(b_if.busy), 32'd0);
        check("to_byte5", 32'((b_got_q.size() > 5) ? b_got_q[5] : 8'h00), 32'(exp_q[5]));
        b_withhold = 0;

        // Mid-frame pulses are dropped; a level held through FIN restarts at once.
        clear_b();
        f = rand_fields();
        build_frame(8'hE7, f);
        build_frame(8'hE7, f);
        d0 = b_done_cnt;
        request_b(8'hE7, f, rc);
        wait_b_bytes("bb_p1", 3, 400);
        @(negedge clk); b_if.enquire_flag = 1'b1;
        @(negedge clk); b_if.enquire_flag = 1'b0;
        wait_b_bytes("bb_p2", 10, 600);
        @(negedge clk); b_if.enquire_flag = 1'b1;
        @(negedge clk); b_if.enquire_flag = 1'b0;
        wait_b_bytes("bb_hold", 28, 1000);
        @(negedge clk); b_if.enquire_flag = 1'b1;
        wait_b_end("bb1", 1000);
        d1 = b_done_cyc;
        wait_b_bytes("bb_second", 31, 200);
        @(negedge clk); b_if.enquire_flag = 1'b0;
        check("bb_gap", 32'((b_start_cyc_q.size() > 30) ? b_start_cyc_q[30] - d1 : -1), 32'd3);
        wait_b_end("bb2", 1000);
        repeat (60) @(negedge clk);
        compare_q("bb_frames", b_got_q, exp_q);
        check("bb_dones", 32'(b_done_cnt - d0), 32'd2);

        // Asynchronous reset while byte 12 is in flight.
        clear_b();
        f = 192'h89abcdef_11223344_55667788_99aabbcc_ddeeff10_a1b2c3d4;
        d0 = b_done_cnt;
        e0 = b_err_cnt;
        request_b(8'h01, f, rc);
        wait_b_bytes("rs_b12", 13, 800);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rs_mid");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        check("rs_no_restart", 32'(b_got_q.size()), 32'd13);
        check("rs_no_done", 32'(b_done_cnt - d0), 32'd0);
        check("rs_no_err", 32'(b_err_cnt - e0), 32'd0);
        clear_b();
        f = rand_fields();
        build_frame(8'h99, f);
        d0 = b_done_cnt;
        request_b(8'h99, f, rc);
        wait_b_end("rs2", 2000);
        repeat (3) @(negedge clk);
        compare_q("rs2_frame", b_got_q, exp_q);
        check("rs2_done", 32'(b_done_cnt - d0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
